// File: rtl/fifo_word_packer.sv
// Drains an 8-bit FIFO and packs four consecutive bytes, little-endian, into 32-bit words.
// A flush request emits any partial word with a byte-keep mask. The output port uses valid/ready.
module fifo_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        empty,
   input  logic [7:0]  data_out,
   output logic        rd_enb,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_keep,
   output logic        busy
);

   logic [31:0] asm_q, asm_d;
   logic [2:0]  idx_q, idx_d, idx_cap;
   logic        rd_pending_q, rd_pending_d;
   logic        flush_req_q, flush_req_d;
   logic [31:0] out_data_q, out_data_d;
   logic [3:0]  out_keep_q, out_keep_d;
   logic        out_valid_q, out_valid_d;

   logic [3:0]  keep_new;
   logic [31:0] lane_mask;
   logic        out_free, flush_act, room, full_go, flush_go, load;

   always_comb begin
      out_free  = !out_valid_q || out_ready;
      flush_act = flush || flush_req_q;

      // When the 4th byte is in flight and the output can take the word on the
      // capture edge, the next read lands in lane 0, so reads keep streaming.
      room   = ((idx_q + {2'b0, rd_pending_q}) < 3'd4) || ((idx_q == 3'd3) && out_free);
      rd_enb = !reset && !empty && !flush_act && (idx_q != 3'd4) && room;

      asm_d   = asm_q;
      idx_cap = idx_q;
      if (rd_pending_q) begin
         asm_d[{idx_q[1:0], 3'b000} +: 8] = data_out;
         idx_cap = idx_q + 3'd1;
      end

      case (idx_cap)
         3'd1:    keep_new = 4'b0001;
         3'd2:    keep_new = 4'b0011;
         3'd3:    keep_new = 4'b0111;
         default: keep_new = 4'b1111;
      endcase
      lane_mask = '0;
      for (int k = 0; k < 4; k++) begin
         lane_mask[8*k +: 8] = {8{keep_new[k]}};
      end

      full_go  = (idx_cap == 3'd4) && out_free;
      // A flush waits for the in-flight byte so that it is included.
      flush_go = flush_act && !rd_pending_q && (idx_q != 3'd0) && out_free;
      load     = full_go || flush_go;

      idx_d        = load ? 3'd0 : idx_cap;
      rd_pending_d = rd_enb;
      flush_req_d  = flush_act && !(!rd_pending_q && ((idx_q == 3'd0) || flush_go));

      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_valid_d = out_valid_q && !out_ready;
      if (load) begin
         out_data_d  = asm_d & lane_mask;
         out_keep_d  = keep_new;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         asm_q        <= '0;
         idx_q        <= '0;
         rd_pending_q <= 1'b0;
         flush_req_q  <= 1'b0;
         out_data_q   <= '0;
         out_keep_q   <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         asm_q        <= asm_d;
         idx_q        <= idx_d;
         rd_pending_q <= rd_pending_d;
         flush_req_q  <= flush_req_d;
         out_data_q   <= out_data_d;
         out_keep_q   <= out_keep_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_keep  = out_keep_q;
   assign busy      = (idx_q != 3'd0) || rd_pending_q || flush_req_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-based FIFO model plus a byte-grouping scoreboard of expected words.
module tb_fifo_word_packer;

   logic        clk = 1'b0;
   logic        reset, empty, flush, out_ready;
   logic [7:0]  data_out;
   logic        rd_enb, out_valid, busy;
   logic [31:0] out_data;
   logic [3:0]  out_keep;

   always #5 clk = ~clk;

   fifo_word_packer dut (
      .clk(clk), .reset(reset), .empty(empty), .data_out(data_out), .rd_enb(rd_enb),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_keep(out_keep), .busy(busy)
   );

   int n_tests = 0, n_fail = 0;
   logic [7:0]  src_q[$];   // FIFO contents
   logic [7:0]  pend[$];    // popped bytes not yet part of an expected word
   logic [35:0] exp_q[$];   // expected {keep, data}
   logic        pop_now;
   logic [7:0]  pop_byte;
   int cyc, rd_cnt, first_rd, last_rd, first_val, fl_cyc;
   int acc_cyc[$];
   logic val_seen;

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] pack_pend();
      logic [31:0] d = '0;
      int n = pend.size();
      for (int i = 0; i < n; i++) d[8*i +: 8] = pend[i];
      return {4'((1 << n) - 1), d};
   endfunction

   task automatic clr_stats();
      rd_cnt = 0; first_rd = -1; last_rd = -1; first_val = -1; val_seen = 1'b0;
      acc_cyc.delete();
   endtask

   task automatic push(input logic [7:0] b);
      src_q.push_back(b);
   endtask

   // One clock cycle: drive at negedge, observe 1ns later, update the model.
   task automatic step(input logic fl, input logic rdy);
      @(negedge clk);
      if (pop_now) data_out = pop_byte;
      pop_now   = 1'b0;
      empty     = (src_q.size() == 0);
      flush     = fl;
      out_ready = rdy;
      #1;
      if (fl) begin
         fl_cyc = cyc;
         chk("rd_blocked_by_flush", rd_enb, 0);
         if (pend.size() != 0) begin
            exp_q.push_back(pack_pend());
            pend.delete();
         end
      end
      if (out_valid) begin
         val_seen = 1'b1;
         if (first_val < 0) first_val = cyc;
      end
      if (out_valid && out_ready) begin
         acc_cyc.push_back(cyc);
         chk("word_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) chk("word", {out_keep, out_data}, exp_q.pop_front());
      end
      if (rd_enb) begin
         chk("rd_when_empty", empty, 0);
         if (!empty) begin
            pop_byte = src_q.pop_front();
            pop_now  = 1'b1;
            pend.push_back(pop_byte);
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (pend.size() == 4) begin
               exp_q.push_back(pack_pend());
               pend.delete();
            end
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; empty = 1'b0; flush = 1'b0; out_ready = 1'b1;
      src_q.delete(); pend.delete(); exp_q.delete(); pop_now = 1'b0;
      #1;
      chk("rst_rd_enb", rd_enb, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_keep", out_keep, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0; empty = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit done;
      reset = 1'b1; empty = 1'b1; flush = 1'b0; out_ready = 1'b0; data_out = '0;
      pop_now = 1'b0; pop_byte = '0; cyc = 0; fl_cyc = 0;
      clr_stats();
      do_reset();

      // single word and its latency
      clr_stats();
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      repeat (8) step(0, 1);
      chk("t1_rd_count", rd_cnt, 4);
      chk("t1_latency", first_val, last_rd + 2);
      chk("t1_left", exp_q.size(), 0);
      chk("t1_busy", busy, 0);

      // sustained streaming
      clr_stats();
      for (int i = 0; i < 12; i++) push(8'(i));
      repeat (18) step(0, 1);
      chk("t2_rd_count", rd_cnt, 12);
      chk("t2_rd_continuous", last_rd - first_rd, 11);
      chk("t2_words", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3) begin
         chk("t2_gap0", acc_cyc[1] - acc_cyc[0], 4);
         chk("t2_gap1", acc_cyc[2] - acc_cyc[1], 4);
      end

      // back-pressure
      clr_stats();
      for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
      repeat (12) step(0, 0);
      chk("t3_pops", rd_cnt, 8);
      chk("t3_fifo_left", src_q.size(), 2);
      chk("t3_rd_stopped", rd_enb, 0);
      chk("t3_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 32'h33323130);
      repeat (3) step(0, 0);
      chk("t3_hold_data2", out_data, 32'h33323130);
      chk("t3_hold_keep", out_keep, 4'b1111);
      repeat (10) step(0, 1);
      step(1, 1);
      repeat (4) step(0, 1);
      chk("t3_left", exp_q.size(), 0);
      chk("t3_rd_total", rd_cnt, 10);

      // partial flush, then flush with nothing held
      clr_stats();
      push(8'hAA); push(8'hBB);
      repeat (4) step(0, 1);
      step(1, 1);
      step(0, 1);
      chk("t4_flush_valid", out_valid, 1);
      chk("t4_flush_data", out_data, 32'h0000BBAA);
      chk("t4_flush_keep", out_keep, 4'b0011);
      repeat (2) step(0, 1);
      clr_stats();
      step(1, 1);
      repeat (4) step(0, 1);
      chk("t4_empty_flush", val_seen, 0);
      chk("t4_busy", busy, 0);

      // flush with a byte in flight
      clr_stats();
      for (int i = 0; i < 5; i++) push(8'(8'h51 + i));
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rd_cnt == 3 && !done) begin
            step(1, 1);
            done = 1'b1;
         end else step(0, 1);
         if (i == 6) chk("t5_flush_lat", first_val, fl_cyc + 2);
      end
      step(1, 1);
      repeat (4) step(0, 1);
      chk("t5_left", exp_q.size(), 0);
      chk("t5_rd_total", rd_cnt, 5);

      // reset mid-word
      clr_stats();
      push(8'h61); push(8'h62); push(8'h63); push(8'h64);
      repeat (3) step(0, 1);
      chk("t6_busy_before", busy, 1);
      do_reset();
      clr_stats();
      push(8'h71); push(8'h72); push(8'h73); push(8'h74);
      repeat (8) step(0, 1);
      chk("t6_rd_count", rd_cnt, 4);
      chk("t6_left", exp_q.size(), 0);
      chk("t6_pend", pend.size(), 0);

      // randomized traffic, flushes and back-pressure
      clr_stats();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 2) == 0 && src_q.size() < 12) push(8'($urandom));
         step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
      end
      repeat (30) step(0, 1);
      step(1, 1);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(0, 1);
      chk("rnd_left", exp_q.size(), 0);
      chk("rnd_pend", pend.size(), 0);
      repeat (2) step(0, 1);
      chk("rnd_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
